// File: rtl/mvau_weight_stream_ctrl.sv
// MVAU weight memory address sequencer with a 2-entry skid buffer on the output stream.
// Define MVAU_WSTREAM_STALL_CNT_EN to add the stall_cnt backpressure counter port.
`timescale 1ns/1ps
module mvau_weight_stream_ctrl #(
    parameter int SIMD         = 2,
    parameter int TW           = 1,
    parameter int WMEM_DEPTH   = 4,
    parameter int WMEM_ADDR_BW = 4,
    parameter int NUM_REPS     = 2,
    parameter int REP_BW       = 16
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [WMEM_ADDR_BW-1:0] wmem_addr,
    input  logic [SIMD*TW-1:0]      wmem_data,
    output logic [SIMD*TW-1:0]      wgt_out,
    output logic                    wgt_v,
    input  logic                    wgt_rdy
`ifdef MVAU_WSTREAM_STALL_CNT_EN
    ,
    output logic [31:0]             stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [WMEM_ADDR_BW-1:0] ADDR_LAST = WMEM_ADDR_BW'(WMEM_DEPTH - 1);
    localparam logic [REP_BW-1:0]       REP_LAST  = REP_BW'(NUM_REPS - 1);

    logic [1:0]         state;
    logic [REP_BW-1:0]  rep;
    logic               inflight;
    logic [1:0]         occ;
    logic [SIMD*TW-1:0] tail_q;

    logic       pop;
    logic       push;
    logic [2:0] slots;
    logic       rd_en;
    logic       addr_wrap;
    logic       last_issue;
    logic       drain_done;

    assign wgt_v = (occ != 2'd0);
    assign pop   = wgt_v && wgt_rdy;
    assign push  = inflight;
    assign busy  = (state != S_IDLE);

    // Buffer slots already claimed: stored words plus the read still in the ROM pipe.
    assign slots = {1'b0, occ} + {2'b00, inflight};
    assign rd_en = (state == S_RUN) &&
                   ((slots < 3'd2) || (pop && (slots == 3'd2)));

    assign addr_wrap  = (wmem_addr == ADDR_LAST);
    assign last_issue = rd_en && addr_wrap && (rep == REP_LAST);
    assign drain_done = (state == S_DRAIN) && !inflight &&
                        ((occ == 2'd0) || ((occ == 2'd1) && pop));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE:  if (start) state <= S_RUN;
                S_RUN:   if (last_issue) state <= S_DRAIN;
                S_DRAIN: begin
                    if (drain_done) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wmem_addr <= '0;
            rep       <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_en;
            if (rd_en) begin
                if (addr_wrap) begin
                    wmem_addr <= '0;
                    rep       <= (rep == REP_LAST) ? '0 : rep + 1'b1;
                end else begin
                    wmem_addr <= wmem_addr + 1'b1;
                end
            end
        end
    end

    // The issue rule keeps slots <= 2, so a push never lands on a full buffer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            occ     <= 2'd0;
            wgt_out <= '0;
            tail_q  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) wgt_out <= wmem_data;
                    else             tail_q  <= wmem_data;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    wgt_out <= tail_q;
                    occ     <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        wgt_out <= wmem_data;
                    end else begin
                        wgt_out <= tail_q;
                        tail_q  <= wmem_data;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MVAU_WSTREAM_STALL_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cnt <= '0;
        end else if ((state == S_IDLE) && start) begin
            stall_cnt <= '0;
        end else if (busy && wgt_v && !wgt_rdy && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
